// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fpu_issue_ctrl
// Brief  : Issue/sequencing stage in front of the FPU arithmetic top. It
//          latches one request, holds it for the arithmetic unit until done
//          or timeout, returns the result on a writeback handshake, and keeps
//          the sticky fflags accumulator.
// Rev    : 1.0  initial release
// ============================================================================
module fpu_issue_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  // request port
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [2:0]        req_rm,
  input  logic              req_rs2_lsb,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [4:0]        req_rd,
  // arithmetic unit
  output logic              arith_start,
  output logic [4:0]        arith_op,
  output logic [2:0]        arith_rm,
  output logic              arith_rs2_lsb,
  output logic [DATA_W-1:0] arith_a,
  output logic [DATA_W-1:0] arith_b,
  input  logic [DATA_W-1:0] arith_out,
  input  logic              arith_done,
  input  logic              arith_nv,
  input  logic              arith_dz,
  input  logic              arith_of,
  input  logic              arith_uf,
  input  logic              arith_nx,
  // writeback port
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic [4:0]        wb_fflags,
  // status
  output logic [4:0]        fflags_acc,
  input  logic              fflags_clr,
  output logic              timeout_err,
  output logic              busy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);
  localparam logic [4:0]    FLAG_NV  = 5'b10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          op_q, op_d;
  logic [2:0]          rm_q, rm_d;
  logic                rs2_q, rs2_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [4:0]          wb_rd_q, wb_rd_d;
  logic [4:0]          wb_ff_q, wb_ff_d;
  logic [4:0]          acc_q, acc_d;
  logic                terr_q, terr_d;
  logic                capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rm_q      <= '0;
      rs2_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_ff_q   <= '0;
      acc_q     <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rm_q      <= rm_d;
      rs2_q     <= rs2_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_ff_q   <= wb_ff_d;
      acc_q     <= acc_d;
      terr_q    <= terr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rm_d      = rm_q;
    rs2_d     = rs2_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    wb_ff_d   = wb_ff_q;
    terr_d    = terr_q;
    capture   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          rm_d    = req_rm;
          rs2_d   = req_rs2_lsb;
          a_d     = req_a;
          b_d     = req_b;
          wb_rd_d = req_rd;
          cnt_d   = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 1'b1;
        // done on the final allowed cycle still wins over the abort
        if (arith_done) begin
          wb_data_d = arith_out;
          wb_ff_d   = {arith_nv, arith_dz, arith_of, arith_uf, arith_nx};
          capture   = 1'b1;
          state_d   = WB;
        end else if (cnt_q == CNT_MAX) begin
          wb_data_d = '0;
          wb_ff_d   = FLAG_NV;
          terr_d    = 1'b1;
          capture   = 1'b1;
          state_d   = WB;
        end
      end
      WB: begin
        if (wb_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // a CSR clear landing on the capture cycle is applied before the OR
    acc_d = acc_q;
    if (capture) begin
      acc_d = (fflags_clr ? 5'b00000 : acc_q) | wb_ff_d;
    end else if (fflags_clr) begin
      acc_d = 5'b00000;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign arith_start   = (state_q == EXEC);
  assign wb_valid      = (state_q == WB);
  assign busy          = (state_q != IDLE);
  assign arith_op      = op_q;
  assign arith_rm      = rm_q;
  assign arith_rs2_lsb = rs2_q;
  assign arith_a       = a_q;
  assign arith_b       = b_q;
  assign wb_data       = wb_data_q;
  assign wb_rd         = wb_rd_q;
  assign wb_fflags     = wb_ff_q;
  assign fflags_acc    = acc_q;
  assign timeout_err   = terr_q;

endmodule
`default_nettype wire

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Issue/sequencing stage that sits directly upstream of the FPU arithmetic top.
- Accepts one FP request from the core pipeline through a valid/ready handshake and latches the operands.
- Drives start/op/rounding mode to the arithmetic unit and holds them stable until done.
- Captures the result and exception flags, presents them on a valid/ready writeback port, and maintains the sticky fflags accumulator for fcsr.

Parameters:
- DATA_W, 32, operand/result width
- TIMEOUT, 64, maximum cycles in EXEC without done before a forced abort

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  stage can accept a request
- req_op  in  5  FPU op code (FADD=00000 … FCLASS/FMV=11100/11110)
- req_rm  in  3  instruction rounding mode / funct3
- req_rs2_lsb  in  1  signed/unsigned select for conversions
- req_a, req_b  in  DATA_W  operands
- req_rd  in  5  destination register tag
- arith_start  out  1  start to arithmetic unit
- arith_op  out  5  registered op
- arith_rm  out  3  registered rounding mode
- arith_rs2_lsb  out  1  registered rs2 lsb
- arith_a, arith_b  out  DATA_W  registered operands
- arith_out  in  DATA_W  arithmetic result
- arith_done  in  1  result valid (may be combinational in the same cycle as start)
- arith_nv, arith_dz, arith_of, arith_uf, arith_nx  in  1 each  exception flags
- wb_valid  out  1  writeback data valid
- wb_ready  in  1  writeback accepted
- wb_data  out  DATA_W  captured result
- wb_rd  out  5  captured destination tag
- wb_fflags  out  5  {NV,DZ,OF,UF,NX} of this op
- fflags_acc  out  5  sticky accumulated fflags
- fflags_clr  in  1  clear accumulator (CSR write)
- timeout_err  out  1  sticky: an op was aborted by timeout
- busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE. All of arith_*, wb_data, wb_rd, wb_fflags, fflags_acc, timeout_err and the cycle counter are 0. req_ready=1, wb_valid=0, busy=0.
- Reset asserted mid-operation: same as above on the next edge. The in-flight op is dropped and its flags are not accumulated.
- The FSM has three states: IDLE, EXEC, WB.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op/rm/rs2_lsb/a/b/rd into the arith_* registers and wb_rd, clear the counter, and go to EXEC.
- EXEC:
  - req_ready=0. arith_start=1 and all arith_* inputs are held constant.
  - The counter increments each cycle.
  - When arith_done=1: capture arith_out into wb_data and the flags into wb_fflags, then go to WB.
  - When the counter reaches TIMEOUT-1 without done: wb_data=0, wb_fflags=5'b10000 (NV), timeout_err<=1, go to WB.
- WB:
  - arith_start=0. This guarantees at least one low cycle of start between consecutive ops.
  - wb_valid=1. wb_data, wb_rd and wb_fflags are stable until handshake.
  - On wb_ready, go to IDLE.
- arith_start is a decoded registered output: high only in EXEC. There is no back-to-back issue, so throughput is at most one op per 3 cycles.
- Latency for an op with same-cycle done: request accepted at edge N, EXEC during cycle N+1, wb_valid asserted after edge N+2.
- Multicycle ops (mul/div/sqrt) stay in EXEC until done.
- fflags_acc update (on capture or timeout):
  - Normal case: fflags_acc <= fflags_acc | new_flags.
  - fflags_clr in the same cycle: fflags_acc <= new_flags (clear applied before OR).
  - fflags_clr with no capture: fflags_acc <= 0.
- Accumulation happens exactly once per op, at capture. A WB stall does not re-accumulate.
- Dynamic rounding (rm=111) is passed through unchanged; resolution is downstream.
- timeout_err is cleared only by reset.

Test Plan:
- FADD: issue op=00000, a=0x3F800000, b=0x40000000, done combinational, wb_ready=1 → wb_valid one cycle, wb_data=0x40400000, wb_fflags=0, busy high for 2 cycles.
- FDIV 1/0: a=0x3F800000, b=0, done after 20 cycles → arith_start held high 20 cycles with constant operands, wb_data=0x7F800000, wb_fflags=01000, fflags_acc=01000.
- Writeback stall: hold wb_ready=0 for 5 cycles after FMUL with NX → wb_data/wb_fflags stable, req_ready=0, fflags_acc ORs NX exactly once.
- Clear collision: fflags_acc=00001, fflags_clr pulses on the capture cycle of an op returning OF → fflags_acc=00100.
- Timeout: arith_done tied 0 → after TIMEOUT cycles wb_data=0, wb_fflags=10000, timeout_err=1, FSM returns to IDLE after wb_ready.
- Reset mid-EXEC of FSQRT: assert reset → next cycle arith_start=0, wb_valid=0, fflags_acc=0, req_ready=1.
